rvv_cmd_dispatch: RTL



---
 rtl/rvv_cmd_dispatch_pkg.sv | 18 +
 rtl/rvv_cmd_dispatch_credit.sv | 47 ++++
 rtl/rvv_cmd_dispatch.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rvv_cmd_dispatch_pkg.sv
// Shared RVV types and constants for the command dispatch slice.
package rvv_cmd_dispatch_pkg;

    localparam int RVV_PERF_CNT_W = 32;

    typedef struct packed {
        logic [7:0] op;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        logic [8:0] imm;
    } RVVCmd;

    function automatic logic [31:0] rvv_min(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/rvv_cmd_dispatch_credit.sv
// In-flight credit tracker: commands popped from the buffer but not yet retired.
module rvv_dispatch_credit #(
    parameter int MAX_INFLIGHT = 8,
    parameter int POP_W        = 3,
    parameter int RET_W        = 2,
    localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POP_W-1:0] pop_i,
    input  logic [RET_W-1:0] retire_i,
    output logic [CW-1:0]    inflight_o,
    output logic [CW-1:0]    avail_o
);

    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_d;
    logic [31:0]   sum_s;

    // Next credit count; a retire beyond what is outstanding clamps at zero.
    always_comb begin
        sum_s = 32'(inflight_q) + 32'(pop_i);
        if (32'(retire_i) > sum_s) begin
            inflight_d = '0;
        end else begin
            inflight_d = CW'(sum_s - 32'(retire_i));
        end
    end

    // Credit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // Backend must never retire more than was issued.
    always @(posedge clk) begin
        retire_underflow_chk: assert (rst || (32'(retire_i) <= sum_s));
    end

    assign inflight_o = inflight_q;
    assign avail_o    = CW'(MAX_INFLIGHT) - inflight_q;

endmodule

// File: rtl/rvv_cmd_dispatch.sv
// RVV command dispatch: drains the command buffer into an ISSUE_W-wide hold stage.
// Optional perf counters are enabled by defining RVV_DISPATCH_PERF_EN.
module rvv_cmd_dispatch
    import rvv_cmd_dispatch_pkg::*;
#(
    parameter int N                       = 4,
    parameter int ISSUE_W                 = 2,
    parameter int CMD_BUFFER_MAX_CAPACITY = 16,
    parameter int MAX_INFLIGHT            = 8,
    localparam int FW = $clog2(CMD_BUFFER_MAX_CAPACITY + 1),
    localparam int PW = $clog2(N + 1),
    localparam int HW = $clog2(ISSUE_W + 1),
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FW-1:0]           fill_level_i,
    input  RVVCmd [N-1:0]           cmd_data_i,
    output logic [PW-1:0]           cmd_ready_o,
    output logic [ISSUE_W-1:0]      issue_valid_o,
    output RVVCmd [ISSUE_W-1:0]     issue_data_o,
    input  logic [ISSUE_W-1:0]      issue_ready_i,
    input  logic [HW-1:0]           retire_count_i,
    output logic                    idle_o
`ifdef RVV_DISPATCH_PERF_EN
    ,
    output logic [RVV_PERF_CNT_W-1:0] perf_issue_count_o,
    output logic [RVV_PERF_CNT_W-1:0] perf_backend_stall_o,
    output logic [RVV_PERF_CNT_W-1:0] perf_credit_stall_o
`endif
);

    RVVCmd [ISSUE_W-1:0] hold_q;
    RVVCmd [ISSUE_W-1:0] hold_d;
    logic [ISSUE_W-1:0]  valid_q;
    logic [ISSUE_W-1:0]  valid_d;
    logic [HW-1:0]       held_q;
    logic [HW-1:0]       held_d;
    logic [31:0]         acc_s;
    logic                acc_run_s;
    logic [31:0]         rem_s;
    logic [31:0]         space_s;
    logic [31:0]         pop_s;
    logic [PW-1:0]       pop_cnt_s;
    logic [CW-1:0]       inflight_s;
    logic [CW-1:0]       avail_s;

    // Accepted count: only an unbroken run of ready slots from slot 0 counts.
    always_comb begin
        acc_s     = 32'd0;
        acc_run_s = 1'b1;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (acc_run_s && valid_q[i] && issue_ready_i[i]) begin
                acc_s = acc_s + 32'd1;
            end else begin
                acc_run_s = 1'b0;
            end
        end
    end

    // Pop count limited by buffer fill, read width, free slots and credits.
    always_comb begin
        rem_s   = 32'(held_q) - acc_s;
        space_s = 32'(ISSUE_W) - rem_s;
        pop_s   = rvv_min(rvv_min(32'(fill_level_i), 32'(N)),
                          rvv_min(space_s, 32'(avail_s)));
        if (rst) begin
            pop_cnt_s = '0;
        end else begin
            pop_cnt_s = PW'(pop_s);
        end
    end

    // Survivors shift down to slot 0, new entries append behind them.
    always_comb begin
        hold_d  = hold_q;
        valid_d = '0;
        held_d  = HW'(rem_s + 32'(pop_cnt_s));
        for (int i = 0; i < ISSUE_W; i++) begin
            for (int j = 0; j < ISSUE_W; j++) begin
                hold_d[i] = ((32'(i) < rem_s) && (32'(j) == 32'(i) + acc_s))
                            ? hold_q[j] : hold_d[i];
            end
            for (int j = 0; j < N; j++) begin
                hold_d[i] = ((32'(i) >= rem_s) && (32'(j) < 32'(pop_cnt_s)) &&
                             (32'(j) + rem_s == 32'(i)))
                            ? cmd_data_i[j] : hold_d[i];
            end
            valid_d[i] = (32'(i) < 32'(held_d));
        end
    end

    // Hold stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            valid_q <= '0;
            held_q  <= '0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    rvv_dispatch_credit #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .POP_W        (PW),
        .RET_W        (HW)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .pop_i      (pop_cnt_s),
        .retire_i   (retire_count_i),
        .inflight_o (inflight_s),
        .avail_o    (avail_s)
    );

    assign cmd_ready_o   = pop_cnt_s;
    assign issue_valid_o = valid_q;
    assign issue_data_o  = hold_q;
    assign idle_o        = (held_q == '0) && (inflight_s == '0) && (fill_level_i == '0);

`ifdef RVV_DISPATCH_PERF_EN
    logic [RVV_PERF_CNT_W-1:0] perf_issue_q;
    logic [RVV_PERF_CNT_W-1:0] perf_bstall_q;
    logic [RVV_PERF_CNT_W-1:0] perf_cstall_q;
    logic                      bstall_s;
    logic                      cstall_s;

    assign bstall_s = valid_q[0] && !issue_ready_i[0];
    // Credit stall: work and room are both available, only credits block the pop.
    assign cstall_s = (fill_level_i != '0) && (space_s != 32'd0) && (avail_s == '0);

    // Wrapping performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_q  <= '0;
            perf_bstall_q <= '0;
            perf_cstall_q <= '0;
        end else begin
            perf_issue_q  <= perf_issue_q + RVV_PERF_CNT_W'(acc_s);
            perf_bstall_q <= perf_bstall_q + RVV_PERF_CNT_W'(bstall_s);
            perf_cstall_q <= perf_cstall_q + RVV_PERF_CNT_W'(cstall_s);
        end
    end

    assign perf_issue_count_o   = perf_issue_q;
    assign perf_backend_stall_o = perf_bstall_q;
    assign perf_credit_stall_o  = perf_cstall_q;
`endif

endmodule
